// File: rtl/multu_hilo_if.sv
// Operand, funct and result bundle shared between the multiplier and its decode/mux logic.
interface multu_hilo_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [5:0]       Signal;
    logic             start;
    logic [WIDTH-1:0] dataOut;
    logic             busy;
    logic             done;

    modport master (
        output dataA, dataB, Signal, start,
        input  dataOut, busy, done
    );

    modport slave (
        input  dataA, dataB, Signal, start,
        output dataOut, busy, done
    );
endinterface

// File: rtl/multu_hilo.sv
// Sequential shift-and-add 32x32 unsigned multiplier writing a HI/LO pair,
// with registered MFHI/MFLO read-back.
module multu_hilo #(
    parameter int unsigned WIDTH = 32,
    parameter logic [5:0]  MULTU = 6'b011001,
    parameter logic [5:0]  MFHI  = 6'b010000,
    parameter logic [5:0]  MFLO  = 6'b010010
) (
    input logic        clk,
    input logic        reset,
    multu_hilo_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   data_out;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] product_next;

    // The final iteration's add must land in HI/LO on the same edge.
    always_comb begin
        product_next = product;
        if (mplier[0]) begin
            product_next = product + mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            product  <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else begin
            // Reads see HI/LO as held before this edge.
            if (bus.Signal == MFHI) begin
                data_out <= hi;
            end else if (bus.Signal == MFLO) begin
                data_out <= lo;
            end else begin
                data_out <= '0;
            end

            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start && (bus.Signal == MULTU)) begin
                        mcand   <= {{WIDTH{1'b0}}, bus.dataA};
                        mplier  <= bus.dataB;
                        product <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    product <= product_next;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        hi    <= product_next[2*WIDTH-1:WIDTH];
                        lo    <= product_next[WIDTH-1:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.dataOut = data_out;
    assign bus.busy    = busy;
    assign bus.done    = done;
endmodule

// File: tb/tb_multu_hilo.sv
// Directed-vector bench for multu_hilo: latency, HI/LO results, ignored starts,
// mid-run reset and read/write ordering.
module tb_multu_hilo;
    localparam logic [5:0] C_MULTU = 6'b011001;
    localparam logic [5:0] C_MFHI  = 6'b010000;
    localparam logic [5:0] C_MFLO  = 6'b010010;
    localparam logic [5:0] C_ADD   = 6'b100000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    multu_hilo_if #(.WIDTH(32)) bus ();

    multu_hilo #(
        .WIDTH(32),
        .MULTU(C_MULTU),
        .MFHI(C_MFHI),
        .MFLO(C_MFLO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [5:0] code, output logic [31:0] val);
        bus.Signal = code;
        tick();
        val = bus.dataOut;
        bus.Signal = 6'd0;
    endtask

    // Starts a multiply and waits (bounded) until the cycle after done, then one more edge.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b);
        bit seen = 0;
        bus.dataA  = a;
        bus.dataB  = b;
        bus.Signal = C_MULTU;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.Signal = 6'd0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus.done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL run_mult_timeout: done not seen, got 0 expected 1");
        end
        tick();
    endtask

    task automatic check_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] v;
        read_reg(C_MFHI, v);
        checks++;
        if (v !== exp_hi) begin
            errors++;
            $display("FAIL %s_hi: got %h expected %h", name, v, exp_hi);
        end
        read_reg(C_MFLO, v);
        checks++;
        if (v !== exp_lo) begin
            errors++;
            $display("FAIL %s_lo: got %h expected %h", name, v, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.dataOut !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got dataOut=%h busy=%b done=%b expected 0 0 0",
                     bus.dataOut, bus.busy, bus.done);
        end
        reset = 1'b1;
        check_hilo("reset", 32'h0, 32'h0);
    endtask

    task automatic test_basic();
        int busy_bad = 0;
        int done_bad = 0;
        bus.dataA  = 32'd3;
        bus.dataB  = 32'd5;
        bus.Signal = C_MULTU;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.Signal = 6'd0;
        // After E0..E31 busy must be high and done low.
        for (int k = 0; k < 32; k++) begin
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.done !== 1'b0) done_bad++;
            if (k < 31) tick();
        end
        checks++;
        if (busy_bad != 0 || done_bad != 0) begin
            errors++;
            $display("FAIL basic_busy_window: busy low %0d times, done high %0d times, expected 0 0",
                     busy_bad, done_bad);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL basic_after_e32: got busy=%b done=%b expected 0 1", bus.busy, bus.done);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_e33: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        check_hilo("basic_3x5", 32'h0, 32'h0000000F);
    endtask

    task automatic test_boundaries();
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_hilo("max", 32'hFFFF_FFFE, 32'h0000_0001);
        run_mult(32'h0001_0000, 32'h0001_0000);
        check_hilo("carry", 32'h0000_0001, 32'h0000_0000);
    endtask

    task automatic test_ignored_start();
        bit seen = 0;
        bus.dataA  = 32'd7;
        bus.dataB  = 32'd9;
        bus.Signal = C_MULTU;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.Signal = 6'd0;
        for (int k = 1; k < 5; k++) tick();
        bus.dataA  = 32'd2;
        bus.dataB  = 32'd2;
        bus.Signal = C_MULTU;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.Signal = 6'd0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus.done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ignored_timeout: done not seen, got 0 expected 1");
        end
        tick();
        check_hilo("ignored_7x9", 32'h0, 32'd63);

        bus.Signal = C_ADD;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL add_start_busy: got %b expected 0", bus.busy);
        end
        tick();
        bus.Signal = 6'd0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL add_start_idle: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        run_mult(32'd6, 32'd7);
        check_hilo("pre_reset_6x7", 32'h0, 32'd42);
        bus.dataA  = 32'h1234;
        bus.dataB  = 32'h10;
        bus.Signal = C_MULTU;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.Signal = 6'd0;
        for (int k = 1; k < 10; k++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midreset_quiet: busy/done seen %0d cycles expected 0", done_seen);
        end
        check_hilo("midreset", 32'h0, 32'h0);
        run_mult(32'd2, 32'd3);
        check_hilo("post_reset_2x3", 32'h0, 32'd6);
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        run_mult(32'd6, 32'd7);
        bus.dataA  = 32'd4;
        bus.dataB  = 32'd4;
        bus.Signal = C_MULTU;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.Signal = C_MFLO;
        // Samples after E1..E32 must still show the old LO.
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (bus.dataOut !== 32'd42) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL collision_old_lo: %0d samples differed from 42, expected 0", bad);
        end
        tick();
        checks++;
        if (bus.dataOut !== 32'd16) begin
            errors++;
            $display("FAIL collision_new_lo: got %0d expected 16", bus.dataOut);
        end
        bus.Signal = 6'd0;
        tick();
    endtask

    initial begin
        bus.dataA  = '0;
        bus.dataB  = '0;
        bus.Signal = '0;
        bus.start  = 1'b0;
        test_reset();
        test_basic();
        test_boundaries();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
